// File: rtl/shot_issuer.sv
// shot_issuer: latches the player's switches on a Fire press and presents the
// move to the validity checker for one scoring cycle. The checker's verdict
// commits or rejects the move. The block tracks big bombs left and accepted
// moves, and parks in DONE once the game is over.
module shot_issuer #(
  parameter logic [1:0]  BIG_INIT = 2'd3,
  parameter int unsigned MOVE_W   = 4
) (
  input  logic              clock,
  input  logic              reset_L,
  input  logic [3:0]        XIn,
  input  logic [3:0]        YIn,
  input  logic              BigIn,
  input  logic              Fire,
  input  logic              SomethingIsWrong,
  input  logic              GameOver,
  output logic [3:0]        X,
  output logic [3:0]        Y,
  output logic              Big,
  output logic              ScoreThis,
  output logic [1:0]        BigLeft,
  output logic [MOVE_W-1:0] NumMoves,
  output logic              MoveAccepted,
  output logic              MoveRejected,
  output logic              Done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          x_q, x_d;
  logic [3:0]          y_q, y_d;
  logic                big_q, big_d;
  logic [1:0]          big_left_q, big_left_d;
  logic [MOVE_W-1:0]   num_moves_q, num_moves_d;
  logic                accepted_q, accepted_d;
  logic                rejected_q, rejected_d;
  logic                fire_prev_q, fire_prev_d;
  logic                fire_edge;

  // Next-state, move latch, verdict handling and counter updates
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    big_d       = big_q;
    big_left_d  = big_left_q;
    num_moves_d = num_moves_q;
    accepted_d  = 1'b0;
    rejected_d  = 1'b0;
    fire_prev_d = Fire;
    fire_edge   = Fire & ~fire_prev_q;

    case (state_q)
      ST_IDLE: begin
        if (GameOver) begin
          state_d = ST_DONE;
        end else if (fire_edge) begin
          x_d     = XIn;
          y_d     = YIn;
          big_d   = BigIn;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!SomethingIsWrong) begin
          accepted_d = 1'b1;
          if (num_moves_q != {MOVE_W{1'b1}}) begin
            num_moves_d = num_moves_q + MOVE_W'(1);
          end
          // Guarded so a checker miss can never wrap the bomb count
          if (big_q && (big_left_q != 2'd0)) begin
            big_left_d = big_left_q - 2'd1;
          end
        end else begin
          rejected_d = 1'b1;
        end
        state_d = GameOver ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; a Fire held through reset must be released first
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state_q     <= ST_IDLE;
      x_q         <= 4'd0;
      y_q         <= 4'd0;
      big_q       <= 1'b0;
      big_left_q  <= BIG_INIT;
      num_moves_q <= '0;
      accepted_q  <= 1'b0;
      rejected_q  <= 1'b0;
      fire_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      big_q       <= big_d;
      big_left_q  <= big_left_d;
      num_moves_q <= num_moves_d;
      accepted_q  <= accepted_d;
      rejected_q  <= rejected_d;
      fire_prev_q <= fire_prev_d;
    end
  end

  // Strobes decoded straight from the state register, glitch-free by construction
  assign ScoreThis    = (state_q == ST_ISSUE);
  assign Done         = (state_q == ST_DONE);
  assign X            = x_q;
  assign Y            = y_q;
  assign Big          = big_q;
  assign BigLeft      = big_left_q;
  assign NumMoves     = num_moves_q;
  assign MoveAccepted = accepted_q;
  assign MoveRejected = rejected_q;

endmodule

// File: doc/shot_issuer.md
Name: shot_issuer

Overview:
- Player-side move generator that produces the X/Y/Big/ScoreThis/BigLeft bundle consumed by the move-validity checker (SomethingIsWrong producer).
- Latches player switches on a Fire press and presents the move for exactly one scoring cycle.
- Uses the checker's verdict to commit or reject the move, tracks remaining big bombs and a move counter, and stops at game over.
- Sits between the board input synchronizers and the checker/scoring datapath.

Parameters:
- BIG_INIT, 2'd3, big bombs available after reset.
- MOVE_W, 4, width of the NumMoves counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_L  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- XIn  input  4  player X switch value, already synchronized.
- YIn  input  4  player Y switch value, already synchronized.
- BigIn  input  1  player requests a big bomb.
- Fire  input  1  synchronized fire button, level; may be held for many cycles.
- SomethingIsWrong  input  1  checker verdict, combinational from X/Y/Big/ScoreThis/BigLeft in the same cycle.
- GameOver  input  1  level from scoring; the game has ended.
- X  output  4  latched move X.
- Y  output  4  latched move Y.
- Big  output  1  latched big-bomb flag.
- ScoreThis  output  1  move-valid strobe to checker/scoring; 1-cycle pulse.
- BigLeft  output  2  big bombs remaining.
- NumMoves  output  MOVE_W  count of accepted moves.
- MoveAccepted  output  1  1-cycle pulse, cycle after an accepted ISSUE.
- MoveRejected  output  1  1-cycle pulse, cycle after a rejected ISSUE.
- Done  output  1  high in DONE state.

Behaviour:
- Reset (reset_L==0 at an edge):
  - State=IDLE; X=0, Y=0, Big=0, ScoreThis=0.
  - BigLeft=BIG_INIT, NumMoves=0, MoveAccepted=0, MoveRejected=0, Done=0.
  - fire_prev=1, so a Fire held through reset does not fire; it must be released first.
  - Reset overrides everything, in any state, including mid-ISSUE; no pulse is emitted and no counter is updated.
- Edge detect: fire_edge = Fire & ~fire_prev; fire_prev <= Fire every cycle.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - If GameOver, go to DONE (GameOver has priority over fire_edge in the same cycle).
  - Else, on fire_edge: X<=XIn, Y<=YIn, Big<=BigIn; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ScoreThis=1, decoded from state so it is high exactly while in ISSUE. X/Y/Big/BigLeft are stable registered values.
  - SomethingIsWrong==0 (accept):
    - NumMoves<=NumMoves+1, saturating at all-ones.
    - If Big and BigLeft!=0, BigLeft<=BigLeft-1.
    - MoveAccepted<=1 next cycle.
  - SomethingIsWrong==1 (reject): no counter change; MoveRejected<=1 next cycle.
  - Next state: DONE if GameOver, else IDLE.
- DONE: terminal; Done=1, ScoreThis=0, all inputs ignored; exits only via reset.
- Output hold: X/Y/Big hold their last latched values outside ISSUE; they change only on a fire_edge in IDLE.
- Fire in ISSUE or DONE: not latched. A press whose rising edge lands in ISSUE is lost; fire_prev still tracks, so no deferred fire.
- BigLeft never underflows; the checker rejects Big with BigLeft==0, and the decrement is guarded regardless.
- Minimum move spacing: fire_edge to ScoreThis is 1 cycle; at most one move per 2 cycles. Back-to-back moves need Fire low for at least 1 cycle.
- Accept and reject pulses are mutually exclusive and never both high.

Test Plan:
- Reset with Fire=1 held, release, press with XIn=3, YIn=5, BigIn=0 -> exactly one ScoreThis pulse 1 cycle after the edge; X=3, Y=5; MoveAccepted pulse; NumMoves=1, BigLeft=3.
- Three accepted big shots (X=2, Y=2, BigIn=1) -> BigLeft 3->2->1->0. Fourth big shot: checker forces SomethingIsWrong=1 -> MoveRejected pulse, BigLeft stays 0, NumMoves stays 3.
- Off-board shot XIn=0, YIn=4 with the checker model connected -> ScoreThis pulse, MoveRejected=1, NumMoves unchanged, X holds 0 afterwards.
- Fire held high 20 cycles -> exactly one ScoreThis. Fire toggled 1,0,1 with a 1-cycle gap -> two ScoreThis pulses 2 cycles apart.
- GameOver asserted in the same cycle as ISSUE -> move still scored; next state DONE, Done=1; further Fire presses produce no ScoreThis.
- reset_L driven low during ISSUE -> next cycle ScoreThis=0, no Accept/Reject pulse, NumMoves=0, BigLeft=3.
